// File: rtl/key_expansion.sv
// AES-128 key expansion: reads the cipher key and an external S-box and fills the
// row-major round-key RAM `word` (address = row*ROW_STRIDE + col), two bytes per write cycle.
module key_expansion #(
    parameter int unsigned ROW_STRIDE = 120,
    parameter int unsigned NR         = 10,
    parameter logic [7:0]  RCON_INIT  = 8'h01
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic [3:0]  key_address0,
    output logic        key_ce0,
    input  logic [31:0] key_q0,
    output logic [7:0]  sbox_address0,
    output logic        sbox_ce0,
    input  logic [31:0] sbox_q0,
    output logic [8:0]  word_address0,
    output logic        word_ce0,
    output logic        word_we0,
    output logic [31:0] word_d0,
    output logic [8:0]  word_address1,
    output logic        word_ce1,
    output logic        word_we1,
    output logic [31:0] word_d1
);

    localparam int unsigned NCOL = 4 * (NR + 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StLoadLast, StSub, StWrA, StWrB, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  col_q, col_d;
    logic [7:0]  rcon_q, rcon_d;
    // w_q[0] is w[i-4], w_q[3] is w[i-1]
    logic [7:0]  w_q [4][4];
    logic [7:0]  w_d [4][4];
    logic [7:0]  temp_q [4];
    logic [7:0]  temp_d [4];
    logic [7:0]  tmp [4];
    logic [7:0]  nw [4];
    logic [3:0]  km1;
    logic [1:0]  rot_row;
    logic        unused_hi;

    assign unused_hi = ^{key_q0[31:8], sbox_q0[31:8]};
    assign km1       = cnt_q - 4'd1;
    assign rot_row   = cnt_q[1:0] + 2'd1;

    function automatic logic [8:0] waddr(input logic [1:0] row, input logic [8:0] col);
        return 9'(32'(row) * ROW_STRIDE) + col;
    endfunction

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            tmp[r] = (col_q[1:0] == 2'd0) ? temp_q[r] : w_q[3][r];
            nw[r]  = w_q[0][r] ^ tmp[r];
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        col_d         = col_q;
        rcon_d        = rcon_q;
        w_d           = w_q;
        temp_d        = temp_q;
        ap_done       = 1'b0;
        ap_ready      = 1'b0;
        ap_idle       = 1'b0;
        key_address0  = cnt_q;
        key_ce0       = 1'b0;
        sbox_address0 = w_q[3][rot_row];
        sbox_ce0      = 1'b0;
        word_address0 = '0;
        word_ce0      = 1'b0;
        word_we0      = 1'b0;
        word_d0       = '0;
        word_address1 = '0;
        word_ce1      = 1'b0;
        word_we1      = 1'b0;
        word_d1       = '0;

        unique case (state_q)
            StIdle: begin
                ap_idle = 1'b1;
                ap_done = ~ap_start;
                if (ap_start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    col_d   = '0;
                    rcon_d  = RCON_INIT;
                end
            end
            StLoad: begin
                key_ce0 = 1'b1;
                // Data for key[cnt-1] arrives this cycle
                if (cnt_q != 4'd0) begin
                    word_ce0      = 1'b1;
                    word_we0      = 1'b1;
                    word_address0 = waddr(km1[1:0], {7'd0, km1[3:2]});
                    word_d0       = {24'd0, key_q0[7:0]};
                    w_d[km1[3:2]][km1[1:0]] = key_q0[7:0];
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = StLoadLast;
            end
            StLoadLast: begin
                word_ce0      = 1'b1;
                word_we0      = 1'b1;
                word_address0 = waddr(2'd3, 9'd3);
                word_d0       = {24'd0, key_q0[7:0]};
                w_d[3][3]     = key_q0[7:0];
                col_d         = 9'd4;
                cnt_d         = '0;
                state_d       = StSub;
            end
            StSub: begin
                sbox_ce0 = (cnt_q < 4'd4);
                // Lookup issued at step s (source row s+1) lands in temp row s one cycle later
                if (cnt_q != 4'd0) begin
                    temp_d[km1[1:0]] = sbox_q0[7:0] ^ ((km1 == 4'd0) ? rcon_q : 8'h00);
                end
                if (cnt_q == 4'd4) begin
                    rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    cnt_d   = '0;
                    state_d = StWrA;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWrA: begin
                word_ce0      = 1'b1;
                word_we0      = 1'b1;
                word_address0 = waddr(2'd0, col_q);
                word_d0       = {24'd0, nw[0]};
                word_ce1      = 1'b1;
                word_we1      = 1'b1;
                word_address1 = waddr(2'd1, col_q);
                word_d1       = {24'd0, nw[1]};
                state_d       = StWrB;
            end
            StWrB: begin
                word_ce0      = 1'b1;
                word_we0      = 1'b1;
                word_address0 = waddr(2'd2, col_q);
                word_d0       = {24'd0, nw[2]};
                word_ce1      = 1'b1;
                word_we1      = 1'b1;
                word_address1 = waddr(2'd3, col_q);
                word_d1       = {24'd0, nw[3]};
                w_d[0] = w_q[1];
                w_d[1] = w_q[2];
                w_d[2] = w_q[3];
                w_d[3] = nw;
                col_d  = col_q + 9'd1;
                if (col_q == 9'(NCOL - 1)) begin
                    state_d = StDone;
                end else if (col_q[1:0] == 2'd3) begin
                    cnt_d   = '0;
                    state_d = StSub;
                end else begin
                    state_d = StWrA;
                end
            end
            StDone: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are held quiet while reset is asserted
        if (ap_rst) begin
            ap_done  = 1'b0;
            ap_ready = 1'b0;
            ap_idle  = 1'b1;
            key_ce0  = 1'b0;
            sbox_ce0 = 1'b0;
            word_ce0 = 1'b0;
            word_we0 = 1'b0;
            word_ce1 = 1'b0;
            word_we1 = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            col_q   <= '0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            rcon_q  <= rcon_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        w_q    <= w_d;
        temp_q <= temp_d;
    end

endmodule

// File: doc/key_expansion.md
Name: key_expansion

Overview:
- Writer-side counterpart of the AES round-key consumer: performs AES-128 key expansion and fills the shared `word` round-key RAM that the AddRoundKey stages read.
- Reads the 16-byte cipher key from a key RAM and substitutes bytes through an external S-box ROM port.
- Writes all 44 columns x 4 rows into `word`, flattened as address = row*ROW_STRIDE + col.
- Uses the ap_start/ap_done/ap_idle/ap_ready block handshake; one run per key.

Parameters:
ROW_STRIDE, 120, word-RAM row pitch (row r base = r*120)
NR, 10, number of rounds; column count NCOL = 4*(NR+1) = 44
RCON_INIT, 8'h01, first round constant

Ports:
ap_clk  in  1  clock
ap_rst  in  1  reset, synchronous, active-high
ap_start  in  1  start request, sampled in IDLE
ap_done  out  1  run complete pulse
ap_idle  out  1  block idle
ap_ready  out  1  ready for new start (pulses with ap_done)
key_address0  out  4  key byte index k (key[k], k = col*4+row)
key_ce0  out  1  key read enable
key_q0  in  32  key data; bits [7:0] used, 1-cycle read latency
sbox_address0  out  8  S-box lookup index
sbox_ce0  out  1  S-box read enable
sbox_q0  in  32  S-box data; bits [7:0] used, 1-cycle latency
word_address0  out  9  round-key write address, port 0
word_ce0  out  1  port 0 enable
word_we0  out  1  port 0 write enable
word_d0  out  32  port 0 data, byte zero-extended
word_address1  out  9  round-key write address, port 1
word_ce1  out  1  port 1 enable
word_we1  out  1  port 1 write enable
word_d1  out  32  port 1 data, byte zero-extended

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - FSM returns to IDLE, col=0, rcon=RCON_INIT.
  - All ce/we outputs are 0, ap_done=0, ap_ready=0, ap_idle=1.
  - Reset mid-run aborts the run: no further writes; partial `word` contents are left as-is.
- Internal state: four columns w[i-4..i-1], 4x4 bytes, held in registers. No `word` read-back is performed.
- FSM states: IDLE, LOAD, LOAD_LAST, SUB, WR_A, WR_B, DONE.
- IDLE:
  - ap_idle=1; ap_done=1 while ap_start=0, matching the codebase handshake.
  - ap_start=1 moves to LOAD; ap_start at any other time is ignored.
- LOAD (16 cycles):
  - Issues key reads k=0..15, one per cycle.
  - The data returned the following cycle is written on port 0 at (k%4)*ROW_STRIDE + k/4 and also stored in the column registers.
- LOAD_LAST: writes k=15; col=4.
- Per column i = 4..43:
  - If i%4==0, enter SUB for 5 cycles.
    - Issues S-box reads of the RotWord bytes of w[i-1], in order: rows 1,2,3,0.
    - Each result is captured one cycle later.
    - temp = sub bytes, with row 0 XORed with rcon.
    - rcon then advances by xtime: rcon<<1, XOR 8'h1b if bit 7 was set. Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - Otherwise temp = w[i-1].
  - WR_A: writes rows 0 and 1 of w[i] = w[i-4]^temp on ports 0 and 1.
  - WR_B: writes rows 2 and 3 of w[i], shifts the column registers, col++.
  - After col 43, go to DONE.
- DONE: ap_done=1 and ap_ready=1 for exactly one cycle, then IDLE.
- Latency: taking the cycle ap_start is accepted as cycle 0, DONE occurs at cycle 148 (1 + 17 + 10*7 + 30*2).
- Address arithmetic: 9-bit unsigned. Maximum address is 3*120 + 43 = 403, so no wrap.
- Write rules:
  - ce=we=1 only in write cycles.
  - Port 0 and port 1 never target the same address in one cycle.
- Addresses and data are don't-care when ce=0.

Test Plan:
- Reset then idle: ap_rst high for 2 cycles, then low with ap_start=0 -> ap_idle=1, ap_done=1, all we=0, no key/sbox ce.
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> `word` addr 4/124/244/364 = 0xa0/0xfa/0xfe/0x17; addr 43/163/283/403 = 0xb6/0x63/0x0c/0xa6; ap_done at cycle 148.
- All-zero key -> column 4 = 0x62,0x63,0x63,0x63; column 43 = 0xb4,0xef,0x5b,0xcb; exactly 176 word writes total.
- ap_start held high through a run and a second start -> two back-to-back runs with identical writes; starts pulsed during busy are ignored.
- ap_rst asserted at cycle 60 -> no writes after reset; a restart with a new key gives the correct full result.
- Scoreboard: every write address < 404; ports 0 and 1 never collide; sbox_ce asserted exactly 40 cycles per run.
